// File: rtl/zeroriscy_bnn_seq.sv
`default_nettype none
// ============================================================================
// Module      : zeroriscy_bnn_seq
// Description : Layer sequencer for the zeroriscy BNN coprocessor. Takes one
//               layer-slice descriptor and drives the BNN command port with
//               ini -> acc x N -> pool (per pooled pixel), then norm -> activ,
//               fetching acc operands from the activation RAM and returning
//               the BNN result word.
// Ports       : clk/rst_n           clock, synchronous active-low reset
//               start_i + desc      slice launch and descriptor
//               act_rd_o/addr/rdata activation RAM read port (1-cycle latency)
//               bnn_*               BNN ex-stage command port + result
//               busy_o              slice in progress
//               res_valid_o/data_o  captured result (one-cycle pulse)
//               done_o              one-cycle pulse after the slice ends
// Revision    : 1.0 - initial release
// ============================================================================
module zeroriscy_bnn_seq #(
    parameter int RES_LAT = 3,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [7:0]    in_words_i,
    input  logic [3:0]    pool_n_i,
    input  logic [AW-1:0] act_base_i,
    input  logic [15:0]   param_base_i,
    input  logic [15:0]   norm_addr_i,
    output logic          act_rd_o,
    output logic [AW-1:0] act_addr_o,
    input  logic [31:0]   act_rdata_i,
    output logic          bnn_en_o,
    output logic [2:0]    bnn_operator_o,
    output logic [31:0]   bnn_addr_o,
    output logic [31:0]   bnn_data_o,
    input  logic          bnn_ready_i,
    input  logic [31:0]   bnn_result_i,
    output logic          busy_o,
    output logic          res_valid_o,
    output logic [31:0]   res_data_o,
    output logic          done_o
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INI   = 4'd1,
        S_FETCH = 4'd2,
        S_ACC   = 4'd3,
        S_POOL  = 4'd4,
        S_NORM  = 4'd5,
        S_ACTIV = 4'd6,
        S_WAIT  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam logic [7:0] C_WAIT_LAST = 8'(RES_LAT - 1);

    state_t        state_q, state_d;
    logic [7:0]    in_words_q, in_words_d;
    logic [3:0]    pool_n_q, pool_n_d;
    logic [15:0]   param_base_q, param_base_d;
    logic [15:0]   norm_addr_q, norm_addr_d;
    logic [AW-1:0] act_ptr_q, act_ptr_d;
    logic [7:0]    w_q, w_d;
    logic [3:0]    p_q, p_d;
    logic [7:0]    wait_q, wait_d;
    logic [31:0]   acc_data_q, acc_data_d;
    logic          acc_hold_q, acc_hold_d;
    logic [31:0]   res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          done_q, done_d;
    logic [15:0]   w_param_addr;

    assign w_param_addr = param_base_q + {8'h00, w_q};

    always_comb begin
        state_d        = state_q;
        in_words_d     = in_words_q;
        pool_n_d       = pool_n_q;
        param_base_d   = param_base_q;
        norm_addr_d    = norm_addr_q;
        act_ptr_d      = act_ptr_q;
        w_d            = w_q;
        p_d            = p_q;
        wait_d         = wait_q;
        acc_data_d     = acc_data_q;
        acc_hold_d     = acc_hold_q;
        res_data_d     = res_data_q;
        res_valid_d    = 1'b0;
        done_d         = 1'b0;
        act_rd_o       = 1'b0;
        act_addr_o     = '0;
        bnn_en_o       = 1'b0;
        bnn_operator_o = 3'd0;
        bnn_addr_o     = 32'h0;
        bnn_data_o     = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    in_words_d   = in_words_i;
                    pool_n_d     = pool_n_i;
                    param_base_d = param_base_i;
                    norm_addr_d  = norm_addr_i;
                    act_ptr_d    = act_base_i;
                    w_d          = 8'h00;
                    p_d          = 4'h0;
                    state_d      = (pool_n_i != 4'h0) ? S_INI : S_DONE;
                end
            end
            S_INI: begin
                bnn_en_o       = 1'b1;
                bnn_operator_o = 3'd0;
                if (bnn_ready_i) begin
                    state_d = (in_words_q != 8'h00) ? S_FETCH : S_POOL;
                end
            end
            S_FETCH: begin
                act_rd_o   = 1'b1;
                act_addr_o = act_ptr_q;
                acc_hold_d = 1'b0;
                state_d    = S_ACC;
            end
            S_ACC: begin
                // Read data is only guaranteed in the first ACC cycle; keep a
                // copy so the command stays stable across a stall.
                bnn_en_o       = 1'b1;
                bnn_operator_o = 3'd1;
                bnn_addr_o     = {16'h0000, w_param_addr};
                bnn_data_o     = acc_hold_q ? acc_data_q : act_rdata_i;
                acc_data_d     = bnn_data_o;
                acc_hold_d     = 1'b1;
                if (bnn_ready_i) begin
                    act_ptr_d = act_ptr_q + 1'b1;
                    w_d       = w_q + 8'd1;
                    state_d   = ((w_q + 8'd1) == in_words_q) ? S_POOL : S_FETCH;
                end
            end
            S_POOL: begin
                bnn_en_o       = 1'b1;
                bnn_operator_o = 3'd2;
                if (bnn_ready_i) begin
                    p_d     = p_q + 4'd1;
                    w_d     = 8'h00;
                    state_d = ((p_q + 4'd1) == pool_n_q) ? S_NORM : S_INI;
                end
            end
            S_NORM: begin
                bnn_en_o       = 1'b1;
                bnn_operator_o = 3'd3;
                bnn_addr_o     = {16'h0000, norm_addr_q};
                if (bnn_ready_i) begin
                    state_d = S_ACTIV;
                end
            end
            S_ACTIV: begin
                bnn_en_o       = 1'b1;
                bnn_operator_o = 3'd4;
                if (bnn_ready_i) begin
                    wait_d  = 8'h00;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == C_WAIT_LAST) begin
                    res_data_d  = bnn_result_i;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DONE: begin
                // done is registered so it lands the cycle after res_valid.
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_words_q   <= 8'h00;
            pool_n_q     <= 4'h0;
            param_base_q <= 16'h0000;
            norm_addr_q  <= 16'h0000;
            act_ptr_q    <= '0;
            w_q          <= 8'h00;
            p_q          <= 4'h0;
            wait_q       <= 8'h00;
            acc_data_q   <= 32'h0;
            acc_hold_q   <= 1'b0;
            res_data_q   <= 32'h0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_words_q   <= in_words_d;
            pool_n_q     <= pool_n_d;
            param_base_q <= param_base_d;
            norm_addr_q  <= norm_addr_d;
            act_ptr_q    <= act_ptr_d;
            w_q          <= w_d;
            p_q          <= p_d;
            wait_q       <= wait_d;
            acc_data_q   <= acc_data_d;
            acc_hold_q   <= acc_hold_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            done_q       <= done_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_bnn_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_zeroriscy_bnn_seq
// Description : Scoreboard bench for zeroriscy_bnn_seq with an activation RAM
//               model and a BNN unit model with controllable ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zeroriscy_bnn_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  in_words_i = 8'h0;
    logic [3:0]  pool_n_i = 4'h0;
    logic [15:0] act_base_i = 16'h0;
    logic [15:0] param_base_i = 16'h0;
    logic [15:0] norm_addr_i = 16'h0;
    logic        act_rd_o;
    logic [15:0] act_addr_o;
    logic [31:0] act_rdata_i = 32'h0;
    logic        bnn_en_o;
    logic [2:0]  bnn_operator_o;
    logic [31:0] bnn_addr_o;
    logic [31:0] bnn_data_o;
    logic        bnn_ready_i;
    logic [31:0] bnn_result_i = 32'h0;
    logic        busy_o;
    logic        res_valid_o;
    logic [31:0] res_data_o;
    logic        done_o;

    logic        ready_fixed = 1'b1;
    logic        rand_ready = 1'b0;
    logic        rnd_bit = 1'b1;
    logic        sb_en = 1'b1;

    assign bnn_ready_i = rand_ready ? rnd_bit : ready_fixed;

    zeroriscy_bnn_seq #(.RES_LAT(3), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .in_words_i(in_words_i), .pool_n_i(pool_n_i), .act_base_i(act_base_i),
        .param_base_i(param_base_i), .norm_addr_i(norm_addr_i),
        .act_rd_o(act_rd_o), .act_addr_o(act_addr_o), .act_rdata_i(act_rdata_i),
        .bnn_en_o(bnn_en_o), .bnn_operator_o(bnn_operator_o),
        .bnn_addr_o(bnn_addr_o), .bnn_data_o(bnn_data_o),
        .bnn_ready_i(bnn_ready_i), .bnn_result_i(bnn_result_i),
        .busy_o(busy_o), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ca;
        logic        cd;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [15:0] exp_rd[$];
    logic [31:0] exp_res[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rv_cnt = 0;

    function automatic logic [31:0] mem_val(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Activation RAM: data valid only the cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (act_rd_o) act_rdata_i <= mem_val(act_addr_o);
        else          act_rdata_i <= $urandom;
        rnd_bit <= 1'($urandom);
    end

    // Monitor: command acceptance, read addresses, results, stall stability.
    logic        stall_prev = 1'b0;
    logic [2:0]  s_op;
    logic [31:0] s_addr, s_data;
    always @(negedge clk) begin
        cmd_t e;
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_en", {31'h0, bnn_en_o}, 32'h1);
                check("stall_op", {29'h0, bnn_operator_o}, {29'h0, s_op});
                check("stall_addr", bnn_addr_o, s_addr);
                check("stall_data", bnn_data_o, s_data);
            end
            stall_prev = bnn_en_o && !bnn_ready_i;
            s_op = bnn_operator_o; s_addr = bnn_addr_o; s_data = bnn_data_o;
            if (sb_en && bnn_en_o && bnn_ready_i) begin
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected_op", {29'h0, bnn_operator_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_cmd.pop_front();
                    check("cmd_op", {29'h0, bnn_operator_o}, {29'h0, e.op});
                    if (e.ca) check("cmd_addr", bnn_addr_o, e.addr);
                    if (e.cd) check("cmd_data", bnn_data_o, e.data);
                end
            end
            if (sb_en && act_rd_o) begin
                if (exp_rd.size() == 0) check("rd_unexpected_addr", {16'h0, act_addr_o}, 32'hFFFF_FFFF);
                else check("rd_addr", {16'h0, act_addr_o}, {16'h0, exp_rd.pop_front()});
            end
            if (res_valid_o) begin
                rv_cnt++;
                if (sb_en) begin
                    if (exp_res.size() == 0) check("res_unexpected", res_data_o, 32'hFFFF_FFFF);
                    else check("res_data", res_data_o, exp_res.pop_front());
                end
            end
            if (done_o) done_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic drive_start(input logic [7:0] iw, input logic [3:0] pn,
                               input logic [15:0] ab, input logic [15:0] pb,
                               input logic [15:0] na);
        @(posedge clk); #1;
        in_words_i = iw; pool_n_i = pn; act_base_i = ab;
        param_base_i = pb; norm_addr_i = na; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        // Scramble the descriptor: the running slice must not see it.
        in_words_i = 8'hFF; pool_n_i = 4'h0; act_base_i = 16'h5555;
        param_base_i = 16'hAAAA; norm_addr_i = 16'h1234;
    endtask

    task automatic run_slice(input logic [7:0] iw, input logic [3:0] pn,
                             input logic [15:0] ab, input logic [15:0] pb,
                             input logic [15:0] na, input logic [31:0] res,
                             input int exp_busy);
        logic [15:0] ptr;
        int d0, r0, busy, cyc, done_at;
        ptr = ab;
        for (int p = 0; p < int'(pn); p++) begin
            exp_cmd.push_back('{3'd0, 32'h0, 32'h0, 1'b1, 1'b1});
            for (int w = 0; w < int'(iw); w++) begin
                exp_rd.push_back(ptr);
                exp_cmd.push_back('{3'd1, {16'h0, pb + 16'(w)}, mem_val(ptr), 1'b1, 1'b1});
                ptr = ptr + 16'd1;
            end
            exp_cmd.push_back('{3'd2, 32'h0, 32'h0, 1'b0, 1'b1});
        end
        if (pn != 4'h0) begin
            exp_cmd.push_back('{3'd3, {16'h0, na}, 32'h0, 1'b1, 1'b0});
            exp_cmd.push_back('{3'd4, 32'h0, 32'h0, 1'b0, 1'b0});
            exp_res.push_back(res);
        end
        bnn_result_i = res;
        d0 = done_cnt; r0 = rv_cnt;
        drive_start(iw, pn, ab, pb, na);
        busy = 0; done_at = -1;
        for (cyc = 0; cyc < 3000 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (busy_o) busy++;
            if (done_o) done_at = cyc;
        end
        check("done_seen", {31'h0, done_at >= 0}, 32'h1);
        if (exp_busy >= 0) begin
            check("busy_cycles", busy, exp_busy);
            check("done_latency", done_at, exp_busy);
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_cnt, d0 + 1);
        check("res_valid_count", rv_cnt, r0 + ((pn != 4'h0) ? 1 : 0));
        check("cmd_queue_left", exp_cmd.size(), 0);
        check("rd_queue_left", exp_rd.size(), 0);
        check("res_queue_left", exp_res.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"}, {31'h0, bnn_en_o}, 32'h0);
        check({tag, "_rd"}, {31'h0, act_rd_o}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
        check({tag, "_rv"}, {31'h0, res_valid_o}, 32'h0);
        check({tag, "_done"}, {31'h0, done_o}, 32'h0);
        check({tag, "_resdata"}, res_data_o, 32'h0);
        check({tag, "_outs"}, bnn_addr_o | bnn_data_o | {29'h0, bnn_operator_o} | {16'h0, act_addr_o}, 32'h0);
    endtask

    initial begin
        int d0, r0, accs;
        logic hit;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Basic slice: 2 accs, 1 pixel.
        run_slice(8'd2, 4'd1, 16'h0010, 16'h0020, 16'h0033, 32'hDEADBEEF, 12);
        // Three pooled pixels, one acc each.
        run_slice(8'd1, 4'd3, 16'h0040, 16'h0100, 16'h0007, 32'h12345678, 18);
        // Random ready drops; param address wraps past 0xFFFF.
        rand_ready = 1'b1;
        run_slice(8'd3, 4'd2, 16'h0200, 16'hFFFE, 16'h0099, 32'hA5A55A5A, -1);
        rand_ready = 1'b0;
        // No pixels: DONE directly, no commands, no result.
        run_slice(8'd4, 4'd0, 16'h0000, 16'h0000, 16'h0000, 32'h0BADF00D, 1);
        // Zero accs per pixel: ini goes straight to pool.
        run_slice(8'd0, 4'd2, 16'h0300, 16'h0400, 16'h0055, 32'h01020304, 10);

        // Reset mid-ACC.
        sb_en = 1'b0;
        d0 = done_cnt; r0 = rv_cnt;
        drive_start(8'd8, 4'd1, 16'h0500, 16'h0600, 16'h0001);
        accs = 0; hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (bnn_en_o && bnn_operator_o == 3'd1) begin
                if (accs == 3) hit = 1'b1;
                else accs++;
            end
        end
        check("reset_reach_acc", {31'h0, hit}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midreset_no_done", done_cnt, d0);
        check("midreset_no_rv", rv_cnt, r0);
        exp_cmd.delete(); exp_rd.delete(); exp_res.delete();
        sb_en = 1'b1;
        run_slice(8'd8, 4'd1, 16'h0700, 16'h0800, 16'h0042, 32'hCAFEF00D, 24);

        // Activation pointer wrap.
        run_slice(8'd2, 4'd1, 16'hFFFF, 16'h0020, 16'h0011, 32'h87654321, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
